// File: rtl/fpu_norm_pipe.sv
// Two-stage normaliser behind the leading-one detector: shifts the mantissa so its MSB is set
// and lowers the biased exponent by the same amount, flagging zero and exponent underflow.
module fpu_norm_pipe #(
    parameter int unsigned MANT_W = 32,
    parameter int unsigned EXP_W  = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [MANT_W-1:0]           mant_i,
    input  logic [EXP_W-1:0]            exp_i,
    input  logic [$clog2(MANT_W)-1:0]   first_one_i,
    input  logic                        no_ones_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [MANT_W-1:0]           mant_o,
    output logic [EXP_W-1:0]            exp_o,
    output logic                        zero_o,
    output logic                        uflow_o
);

    localparam int unsigned LZ_W   = $clog2(MANT_W);
    localparam int unsigned DIFF_W = EXP_W + 1;

    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic [LZ_W-1:0]   s1_lz;
    logic              s1_no_ones;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_uflow;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_fire;
    logic              s1_move;
    logic [DIFF_W-1:0] diff;
    logic              diff_uflow;

    // Handshake: a stage may take new data when empty or when its content leaves this edge.
    assign s2_adv     = !out_valid_o || out_ready_i;
    assign s1_adv     = !s1_valid || s2_adv;
    assign in_ready_o = s1_adv;
    assign in_fire    = in_valid_i && s1_adv;
    assign s1_move    = s1_valid && s2_adv;

    // One extra bit so a shift larger than the exponent shows up as a negative result.
    assign diff       = {1'b0, exp_i} - DIFF_W'(first_one_i);
    assign diff_uflow = diff[DIFF_W-1] || (diff == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_mant     <= '0;
            s1_lz       <= '0;
            s1_no_ones  <= 1'b0;
            s1_exp      <= '0;
            s1_uflow    <= 1'b0;
            out_valid_o <= 1'b0;
            mant_o      <= '0;
            exp_o       <= '0;
            zero_o      <= 1'b0;
            uflow_o     <= 1'b0;
        end else if (flush_i) begin
            s1_valid    <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid   <= 1'b1;
                s1_mant    <= mant_i;
                s1_lz      <= first_one_i;
                s1_no_ones <= no_ones_i;
                s1_exp     <= diff[EXP_W-1:0];
                s1_uflow   <= diff_uflow;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            // Zero wins over underflow; underflow pins the exponent to 0 but keeps the shift.
            if (s1_move) begin
                out_valid_o <= 1'b1;
                if (s1_no_ones) begin
                    mant_o  <= '0;
                    exp_o   <= '0;
                    zero_o  <= 1'b1;
                    uflow_o <= 1'b0;
                end else begin
                    mant_o  <= s1_mant << s1_lz;
                    exp_o   <= s1_uflow ? '0 : s1_exp;
                    zero_o  <= 1'b0;
                    uflow_o <= s1_uflow;
                end
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Directed and random checks of fpu_norm_pipe against a scoreboard fed by a behavioural reference model.
module tb_fpu_norm_pipe;

    typedef struct packed {
        logic [31:0] mant;
        logic [8:0]  exp;
        logic        zero;
        logic        uflow;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] mant_i = '0;
    logic [8:0]  exp_i = '0;
    logic [4:0]  first_one_i = '0;
    logic        no_ones_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] mant_o;
    logic [8:0]  exp_o;
    logic        zero_o;
    logic        uflow_o;

    int   checks = 0;
    int   passed = 0;
    res_t sb[$];
    bit   last_in_fire;
    bit   last_out_fire;
    int   outs;

    fpu_norm_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mant_i      (mant_i),
        .exp_i       (exp_i),
        .first_one_i (first_one_i),
        .no_ones_i   (no_ones_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .mant_o      (mant_o),
        .exp_o       (exp_o),
        .zero_o      (zero_o),
        .uflow_o     (uflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] lzc(input logic [31:0] m);
        for (int i = 31; i >= 0; i--)
            if (m[i]) return 5'(31 - i);
        return 5'd0;
    endfunction

    function automatic res_t model(input logic [31:0] m, input logic [8:0] e,
                                   input logic [4:0] lz, input logic nz);
        res_t r;
        int   d;
        d = int'(e) - int'(lz);
        if (nz) begin
            r = '{mant: 32'h0, exp: 9'h0, zero: 1'b1, uflow: 1'b0};
        end else begin
            r.mant  = m << lz;
            r.zero  = 1'b0;
            r.uflow = (d <= 0);
            r.exp   = r.uflow ? 9'd0 : 9'(d);
        end
        return r;
    endfunction

    // One clock: observe at the falling edge, update the scoreboard, then step past the rising edge.
    task automatic step();
        res_t exp_r;
        @(negedge clk);
        last_out_fire = out_valid_o && out_ready_i && !rst_i && !flush_i;
        last_in_fire  = in_valid_i && in_ready_o && !rst_i && !flush_i;
        if (last_out_fire) begin
            outs++;
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(mant_o), 64'hDEAD);
            end else begin
                exp_r = sb.pop_front();
                check("result", 64'({mant_o, exp_o, zero_o, uflow_o}), 64'(exp_r));
            end
        end
        if (rst_i || flush_i) sb.delete();
        else if (last_in_fire) sb.push_back(model(mant_i, exp_i, first_one_i, no_ones_i));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] m, input logic [8:0] e,
                        input logic [4:0] lz, input logic nz);
        int n;
        mant_i = m; exp_i = e; first_one_i = lz; no_ones_i = nz;
        in_valid_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) check("send_timeout", 64'(n), 64'(0));
        in_valid_i = 1'b0;
    endtask

    task automatic send_norm(input logic [31:0] m, input logic [8:0] e);
        send(m, e, lzc(m), m == 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'(0));
        check({tag, "_mant"},      64'(mant_o),      64'(0));
        check({tag, "_exp"},       64'(exp_o),       64'(0));
        check({tag, "_zero"},      64'(zero_o),      64'(0));
        check({tag, "_uflow"},     64'(uflow_o),     64'(0));
        check({tag, "_in_ready"},  64'(in_ready_o),  64'(1));
    endtask

    initial begin
        int n;
        outs = 0;
        repeat (3) step();
        rst_i = 1'b0;
        check_reset_state("reset");

        // Directed cases with latency checks
        out_ready_i = 1'b1;
        send(32'h0000_8000, 9'd150, 5'd16, 1'b0);
        check("lat_t1_early", 64'(out_valid_o), 64'(0));
        step();
        check("lat_t1_valid", 64'(out_valid_o), 64'(1));
        check("t1_value", 64'({mant_o, exp_o, zero_o, uflow_o}),
              64'({32'h8000_0000, 9'd134, 1'b0, 1'b0}));
        step();
        send(32'h0, 9'd100, 5'd7, 1'b1);
        step();
        check("t2_value", 64'({mant_o, exp_o, zero_o, uflow_o}),
              64'({32'h0, 9'd0, 1'b1, 1'b0}));
        step();
        send(32'h0000_0001, 9'd31, 5'd31, 1'b0);
        step();
        check("t3_value", 64'({mant_o, exp_o, zero_o, uflow_o}),
              64'({32'h8000_0000, 9'd0, 1'b0, 1'b1}));
        step();
        send(32'h0000_0003, 9'd5, 5'd30, 1'b0);
        repeat (3) step();

        // Back-pressure: only two entries fit, then a bubble-free drain
        out_ready_i = 1'b0;
        send_norm(32'h0000_00F0, 9'd200);
        send_norm(32'h1234_5678, 9'd3);
        mant_i = 32'h0000_0100; exp_i = 9'd40; first_one_i = lzc(32'h100); no_ones_i = 1'b0;
        in_valid_i = 1'b1;
        step();
        check("bp_blocked", 64'(last_in_fire), 64'(0));
        check("bp_in_ready", 64'(in_ready_o), 64'(0));
        out_ready_i = 1'b1;
        outs = 0;
        send_norm(32'h0000_0100, 9'd40);
        check("bp_same_edge", 64'(outs), 64'(1));
        send_norm(32'h8000_0000, 9'd1);
        send_norm(32'h0000_0000, 9'd77);
        step(); step();
        check("bp_no_bubble", 64'(outs), 64'(5));
        check("bp_drained", 64'(sb.size()), 64'(0));

        // Flush with a concurrent input drops everything
        out_ready_i = 1'b0;
        send_norm(32'h0000_1000, 9'd90);
        send_norm(32'h0000_2000, 9'd91);
        mant_i = 32'h0000_4000; in_valid_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_out_valid", 64'(out_valid_o), 64'(0));
        check("flush_in_ready", 64'(in_ready_o), 64'(1));
        out_ready_i = 1'b1;
        outs = 0;
        repeat (5) step();
        check("flush_no_output", 64'(outs), 64'(0));

        // Reset mid-stream
        out_ready_i = 1'b0;
        send_norm(32'h0000_0055, 9'd60);
        send_norm(32'h0001_0000, 9'd70);
        check("rst_pre_valid", 64'(out_valid_o), 64'(1));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_state("midrst");

        // Random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] m;
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'h1 << $urandom_range(0, 31);
                default: m = $urandom() >> $urandom_range(0, 31);
            endcase
            mant_i      = m;
            exp_i       = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 40)) : 9'($urandom());
            no_ones_i   = (m == 32'h0);
            first_one_i = no_ones_i ? 5'($urandom()) : lzc(m);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 20) begin
            step();
            n++;
        end
        check("random_drain", 64'(sb.size()), 64'(0));
        check("random_idle", 64'(out_valid_o), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
